unified_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the CPU instruction-fetch requester and the CPU load/store requester. Sits between the CPU core's fetch/dmem handshakes and the memory/bus port. Allows one outstanding transaction at a time. Data accesses have fixed priority, with a bounded-starvation guard so fetch always makes progress. Responses are routed back to the requester that owns the transaction.

---
 rtl/unified_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. One transaction in flight at a time. Data requests win by
// default; fetch is forced through after STARVE_LIMIT consecutive data grants
// that it lost. Responses are steered back to whichever side owns the
// transaction.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_data,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,

    output logic              busy,
    output logic              err_stray_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    state_e              state_q;
    logic                owner_q;
    logic [3:0]          starve_cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                mem_req_valid_q;
    logic                busy_q;
    logic                err_q;

    logic                grant_d;
    logic                grant_if;
    logic                resp_fire;

    // Grant decision, only meaningful while idle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch cannot be inferred.
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            grant_d  = d_req_valid && !(if_req_valid && (starve_cnt_q == LIMIT));
            grant_if = if_req_valid && !grant_d;
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    // Responses pass straight through to the owner in the cycle they arrive.
    assign resp_fire     = (state_q == WAIT) && mem_resp_valid;
    assign if_resp_valid = resp_fire && (owner_q == OWNER_IF);
    assign d_resp_valid  = resp_fire && (owner_q == OWNER_D);
    assign if_resp_data  = mem_resp_data;
    assign d_resp_data   = mem_resp_data;

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_we     = we_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_data   = data_q;
    assign busy           = busy_q;
    assign err_stray_resp = err_q;

    // Transaction FSM: latches the winning request, holds it to memory until
    // accepted, then waits for the single response.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the latched request fields are cleared too, so the memory
            // port never shows stale values from an abandoned transaction.
            state_q         <= IDLE;
            owner_q         <= OWNER_IF;
            starve_cnt_q    <= '0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values of the others, independent of statement order.
            if (mem_resp_valid && (state_q != WAIT)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q         <= OWNER_D;
                        we_q            <= d_req_we;
                        addr_q          <= d_req_addr;
                        data_q          <= d_req_data;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= REQ;
                        // Only a data win over a waiting fetch counts as starvation.
                        if (!if_req_valid) begin
                            starve_cnt_q <= '0;
                        end else if (starve_cnt_q != LIMIT) begin
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                        end
                    end else if (grant_if) begin
                        owner_q         <= OWNER_IF;
                        we_q            <= 1'b0;
                        addr_q          <= if_req_addr;
                        data_q          <= '0;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= REQ;
                        starve_cnt_q    <= '0;
                    end else if (!if_req_valid) begin
                        starve_cnt_q <= '0;
                    end
                end

                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end

                WAIT: begin
                    if (mem_resp_valid) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    mem_req_valid_q <= 1'b0;
                    busy_q          <= 1'b0;
                    state_q         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a bench-side memory responder, a
// transaction-level reference model compared every cycle, and directed
// scenarios with literal timing/data expectations.
module tb_unified_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_req_valid, if_req_ready, if_resp_valid;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_resp_data;
    logic          d_req_valid, d_req_ready, d_req_we, d_resp_valid;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_data, d_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          busy, err_stray_resp;

    always #5 clock = ~clock;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_data(d_req_data),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .err_stray_resp(err_stray_resp)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem_arr [logic [31:0]];
    int          stall_left   = 0;
    int          resp_lat     = 1;
    int          pend         = 0;
    bit          inject_stray = 0;
    logic        n_acc, n_rst, n_we, p_we;
    logic [31:0] n_addr, n_data, p_addr, p_data;

    always @(negedge clock) begin
        n_acc  = (mem_req_valid === 1'b1) && (mem_req_ready === 1'b1);
        n_rst  = reset;
        n_we   = mem_req_we;
        n_addr = mem_req_addr;
        n_data = mem_req_data;
    end

    always @(posedge clock) begin
        bit fire;
        #1;
        fire = 0;
        mem_resp_valid = 1'b0;
        if (n_rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) fire = 1;
            end
            if (n_acc) begin
                p_we = n_we; p_addr = n_addr; p_data = n_data;
                pend = resp_lat - 1;
                if (pend == 0) fire = 1;
            end
        end
        if (fire) begin
            mem_resp_valid = 1'b1;
            if (p_we) begin
                mem_arr[p_addr] = p_data;
                mem_resp_data = 32'h0;
            end else begin
                mem_resp_data = mem_arr.exists(p_addr) ? mem_arr[p_addr] : mem_default(p_addr);
            end
        end else if (inject_stray) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h5757_5757;
            inject_stray   = 0;
        end
        if (mem_req_valid === 1'b1 && stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
        end else begin
            mem_req_ready = (mem_req_valid === 1'b1);
        end
    end

    // ---------------- reference model ----------------
    // A transaction is either absent, offered to memory, or accepted and
    // awaiting its response. Expected outputs follow from that plus the
    // arbitration rule.
    typedef enum {PH_NONE, PH_OFFERED, PH_ACCEPTED} phase_t;
    bit          model_on = 0;
    phase_t      ph       = PH_NONE;
    bit          m_is_data, m_we, m_err;
    logic [31:0] m_addr, m_data;
    int          m_streak = 0;
    logic [31:0] shadow [logic [31:0]];

    always @(negedge clock) begin
        if (model_on) begin
            bit win_d, win_if, forced, rsp;
            logic [31:0] rd;
            forced = if_req_valid && (m_streak >= LIM);
            win_d  = (ph == PH_NONE) && d_req_valid && !forced;
            win_if = (ph == PH_NONE) && if_req_valid && !win_d;
            rsp    = (ph == PH_ACCEPTED) && mem_resp_valid;
            rd     = shadow.exists(m_addr) ? shadow[m_addr] : mem_default(m_addr);

            check("m_if_req_ready", if_req_ready, win_if);
            check("m_d_req_ready", d_req_ready, win_d);
            check("m_busy", busy, ph != PH_NONE);
            check("m_mem_req_valid", mem_req_valid, ph == PH_OFFERED);
            check("m_err_stray", err_stray_resp, m_err);
            check("m_if_resp_valid", if_resp_valid, rsp && !m_is_data);
            check("m_d_resp_valid", d_resp_valid, rsp && m_is_data);
            if (ph == PH_OFFERED) begin
                check("m_mem_req_addr", mem_req_addr, m_addr);
                check("m_mem_req_we", mem_req_we, m_we);
                if (m_we) check("m_mem_req_data", mem_req_data, m_data);
            end
            if (rsp && !m_is_data) check("m_if_resp_data", if_resp_data, rd);
            if (rsp && m_is_data && !m_we) check("m_d_resp_data", d_resp_data, rd);

            if (reset) begin
                ph = PH_NONE; m_streak = 0; m_err = 0;
            end else begin
                if (mem_resp_valid && ph != PH_ACCEPTED) m_err = 1;
                case (ph)
                    PH_NONE: begin
                        if (win_d) begin
                            ph = PH_OFFERED; m_is_data = 1; m_we = d_req_we;
                            m_addr = d_req_addr; m_data = d_req_data;
                            m_streak = if_req_valid ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
                        end else if (win_if) begin
                            ph = PH_OFFERED; m_is_data = 0; m_we = 0;
                            m_addr = if_req_addr; m_streak = 0;
                        end else if (!if_req_valid) begin
                            m_streak = 0;
                        end
                    end
                    PH_OFFERED: if (mem_req_ready) ph = PH_ACCEPTED;
                    default: if (mem_resp_valid) begin
                        if (m_we) shadow[m_addr] = m_data;
                        ph = PH_NONE;
                    end
                endcase
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("wait_idle_timeout", 64'(n), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] order;
        int         grants;

        reset = 1'b1;
        if_req_valid = 0; if_req_addr = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_data = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        mem_arr[32'h100] = 32'hDEAD_BEEF;
        shadow[32'h100]  = 32'hDEAD_BEEF;

        @(posedge clock); #1;
        model_on = 1;
        tick();
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_err", err_stray_resp, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);

        // Fetch only, minimum latency
        tick();
        if_req_valid = 1; if_req_addr = 32'h100;
        @(negedge clock);
        check("f_if_ready_T", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        @(negedge clock);
        check("f_mem_valid_T1", mem_req_valid, 1);
        check("f_mem_addr_T1", mem_req_addr, 32'h100);
        check("f_mem_we_T1", mem_req_we, 0);
        @(negedge clock);
        check("f_resp_valid_T2", if_resp_valid, 1);
        check("f_resp_data_T2", if_resp_data, 32'hDEAD_BEEF);
        @(negedge clock);
        check("f_busy_T3", busy, 0);

        // Simultaneous requests: data store first, then fetch
        tick();
        if_req_valid = 1; if_req_addr = 32'h104;
        d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h200; d_req_data = 32'h55;
        @(negedge clock);
        check("s_d_ready", d_req_ready, 1);
        check("s_if_ready", if_req_ready, 0);
        tick();
        d_req_valid = 0;
        @(negedge clock);
        check("s_mem_we", mem_req_we, 1);
        check("s_mem_addr", mem_req_addr, 32'h200);
        check("s_mem_data", mem_req_data, 32'h55);
        @(negedge clock);
        check("s_d_ack", d_resp_valid, 1);
        @(negedge clock);
        check("s_if_ready_next", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        wait_idle();

        // Load back the stored word
        tick();
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h200;
        tick();
        d_req_valid = 0;
        @(negedge clock);
        @(negedge clock);
        check("ld_valid", d_resp_valid, 1);
        check("ld_data", d_resp_data, 32'h55);
        wait_idle();

        // Starvation: both held continuously
        tick();
        if_req_valid = 1; if_req_addr = 32'h300;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h304;
        order = '0; grants = 0;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            @(negedge clock);
            if (if_req_ready) begin order = {order[8:0], 1'b1}; grants++; end
            else if (d_req_ready) begin order = {order[8:0], 1'b0}; grants++; end
        end
        tick();
        if_req_valid = 0; d_req_valid = 0;
        check("st_grant_count", 64'(grants), 64'(10));
        check("st_grant_order", order, 10'b0000100001);
        wait_idle();

        // Back-pressure: 5 stalled cycles then accept
        stall_left = 5;
        tick();
        d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h400; d_req_data = 32'hCAFE_F00D;
        @(negedge clock);
        check("bp_d_ready", d_req_ready, 1);
        tick();
        d_req_valid = 0; if_req_valid = 1; if_req_addr = 32'h108;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid_hold", mem_req_valid, 1);
            check("bp_not_ready", mem_req_ready, 0);
            check("bp_addr", mem_req_addr, 32'h400);
            check("bp_data", mem_req_data, 32'hCAFE_F00D);
            check("bp_we", mem_req_we, 1);
            check("bp_if_ready_low", if_req_ready, 0);
            check("bp_d_ready_low", d_req_ready, 0);
        end
        @(negedge clock);
        check("bp_accept", mem_req_valid && mem_req_ready, 1);
        @(negedge clock);
        check("bp_ack", d_resp_valid, 1);
        @(negedge clock);
        check("bp_if_next", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        wait_idle();

        // Stray response while idle
        @(negedge clock);
        inject_stray = 1;
        @(negedge clock);
        check("sr_no_if_resp", if_resp_valid, 0);
        check("sr_no_d_resp", d_resp_valid, 0);
        check("sr_busy", busy, 0);
        @(negedge clock);
        check("sr_err_set", err_stray_resp, 1);
        check("sr_still_idle", busy, 0);

        // Reset while waiting for a response
        resp_lat = 4;
        tick();
        if_req_valid = 1; if_req_addr = 32'h10C;
        @(negedge clock);
        check("rw_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        @(negedge clock);
        check("rw_accept", mem_req_valid && mem_req_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        resp_lat = 1;
        @(negedge clock);
        check("rw_busy", busy, 0);
        check("rw_mem_valid", mem_req_valid, 0);
        check("rw_if_resp", if_resp_valid, 0);
        check("rw_err_cleared", err_stray_resp, 0);
        tick();
        if_req_valid = 1; if_req_addr = 32'h100;
        @(negedge clock);
        check("rw_regrant", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        @(negedge clock);
        @(negedge clock);
        check("rw_resp", if_resp_valid, 1);
        check("rw_resp_data", if_resp_data, 32'hDEAD_BEEF);
        wait_idle();
        repeat (3) @(negedge clock);
        check("end_err_clear", err_stray_resp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
